// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - requester/consumer handshake bundle for the round-robin mux arbiter
interface mux_rr_arbiter_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int IW = $clog2(N)
) ();
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_idx;
    logic           out_ready;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_idx
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_idx
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter feeding a single registered output slot
module mux_rr_arbiter #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  bus
);
    logic [IW-1:0] ptr;
    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic [IW-1:0] out_idx_q;

    logic          load;
    logic          any_valid;
    logic          found;
    logic [IW:0]   pos;
    logic [IW-1:0] winner;
    logic [IW-1:0] ptr_next;
    logic [W-1:0]  win_data;
    logic [N-1:0]  ready_vec;

    assign load      = !out_valid_q || bus.out_ready;
    assign any_valid = |bus.req_valid;

    // Rotated priority search starting at ptr; one subtraction wraps since ptr < N.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        pos    = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!found && bus.req_valid[pos[IW-1:0]]) begin
                found  = 1'b1;
                winner = pos[IW-1:0];
            end
        end
    end

    always_comb begin
        win_data  = '0;
        ready_vec = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == IW'(i)) begin
                win_data     = bus.req_data[i*W +: W];
                ready_vec[i] = load && found;
            end
        end
    end

    assign ptr_next = (winner == IW'(N-1)) ? '0 : winner + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            ptr         <= '0;
        end else if (load) begin
            if (any_valid) begin
                out_valid_q <= 1'b1;
                out_data_q  <= win_data;
                out_idx_q   <= winner;
                ptr         <= ptr_next;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.N(N), .W(W), .IW(IW)) bus ();
    mux_rr_arbiter #(.N(N), .W(W), .IW(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    logic [W-1:0] din [N];
    always_comb begin
        for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = din[i];
    end

    // Reference model state
    int           m_ptr;
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_idx;

    function automatic int m_winner(int p, logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready(logic [N-1:0] v, logic ordy);
        int w;
        w = m_winner(m_ptr, v);
        if ((!m_valid || ordy) && w >= 0) return N'(1) << w;
        return '0;
    endfunction

    task automatic m_reset();
        m_ptr = 0; m_valid = 0; m_data = '0; m_idx = 0;
    endtask

    task automatic m_edge(logic [N-1:0] v, logic ordy);
        int w;
        if (!m_valid || ordy) begin
            w = m_winner(m_ptr, v);
            if (w >= 0) begin
                m_data = din[w]; m_idx = w; m_valid = 1; m_ptr = (w + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) din[i] = '0;
        rst_n = 1'b0;
        #3;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
        checks++; if (bus.out_idx !== 2'd0) begin failures++; $display("FAIL reset_out_idx got=%0h exp=0", bus.out_idx); end
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%0h exp=0", bus.req_ready); end
        tick();
        rst_n = 1'b1;
        bus.req_valid = 4'b0001;
        din[0] = 8'h99;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h99) begin failures++; $display("FAIL pre_reset_load got=%0h/%0h exp=1/99", bus.out_valid, bus.out_data); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%0h exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL midreset_out_data got=%0h exp=0", bus.out_data); end
        checks++; if (bus.out_idx !== 2'd0) begin failures++; $display("FAIL midreset_out_idx got=%0h exp=0", bus.out_idx); end
        tick();
        rst_n = 1'b1;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < N; i++) din[i] = 8'h40 + 8'(i);
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL post_reset_ready got=%0h exp=1", bus.req_ready); end
        tick();
        checks++; if (bus.out_idx !== 2'd0 || bus.out_data !== 8'h40) begin failures++; $display("FAIL post_reset_grant got=%0h/%0h exp=0/40", bus.out_idx, bus.out_data); end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        logic [W-1:0] vals [3];
        vals = '{8'hA5, 8'h5A, 8'h3C};
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            din[2] = vals[k];
            #1;
            checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready[%0d] got=%0h exp=4", k, bus.req_ready); end
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd2 || bus.out_data !== vals[k]) begin
                failures++; $display("FAIL single_word[%0d] got=%0h/%0h/%0h exp=1/2/%0h", k, bus.out_valid, bus.out_idx, bus.out_data, vals[k]);
            end
        end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) din[i] = 8'h10 + 8'(i);
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int g = 0; g < 8; g++) begin
            #1;
            checks++; if (bus.req_ready !== (4'b0001 << (g % 4))) begin failures++; $display("FAIL rr_ready[%0d] got=%0h exp=%0h", g, bus.req_ready, 4'b0001 << (g % 4)); end
            tick();
            checks++; if (bus.out_idx !== 2'(g % 4) || bus.out_data !== 8'h10 + 8'(g % 4)) begin
                failures++; $display("FAIL rr_word[%0d] got=%0h/%0h exp=%0h/%0h", g, bus.out_idx, bus.out_data, g % 4, 8'h10 + 8'(g % 4));
            end
        end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_skip_wrap();
        int exp_seq [3];
        exp_seq = '{3, 1, 3};
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0100;
        din[2] = 8'h52;
        tick();
        bus.req_valid = 4'b1010;
        din[1] = 8'h61;
        din[3] = 8'h63;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.req_ready !== (4'b0001 << exp_seq[k])) begin failures++; $display("FAIL skip_ready[%0d] got=%0h exp=%0h", k, bus.req_ready, 4'b0001 << exp_seq[k]); end
            tick();
            checks++; if (bus.out_idx !== 2'(exp_seq[k])) begin failures++; $display("FAIL skip_idx[%0d] got=%0h exp=%0h", k, bus.out_idx, exp_seq[k]); end
        end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_back_pressure();
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0001;
        din[0] = 8'h77;
        tick();
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < N; i++) din[i] = 8'h20 + 8'(i);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%0h exp=0", c, bus.req_ready); end
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h77 || bus.out_idx !== 2'd0) begin
                failures++; $display("FAIL bp_hold[%0d] got=%0h/%0h/%0h exp=1/77/0", c, bus.out_valid, bus.out_data, bus.out_idx);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_ready got=%0h exp=2", bus.req_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd1 || bus.out_data !== 8'h21) begin
            failures++; $display("FAIL bp_release_word got=%0h/%0h/%0h exp=1/1/21", bus.out_valid, bus.out_idx, bus.out_data);
        end
    endtask

    task automatic test_drain();
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL drain_ready got=%0h exp=0", bus.req_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%0h exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h21 || bus.out_idx !== 2'd1) begin failures++; $display("FAIL drain_hold got=%0h/%0h exp=21/1", bus.out_data, bus.out_idx); end
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        logic         ordy;
        v = '0;
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        do_reset();
        m_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && ($urandom % 2 == 0)) begin
                    v[i] = 1'b1;
                    din[i] = 8'($urandom);
                end
            end
            ordy = ($urandom % 4) != 0;
            bus.req_valid = v;
            bus.out_ready = ordy;
            #1;
            exp_rdy = m_ready(v, ordy);
            checks++; if (bus.req_ready !== exp_rdy) begin failures++; $display("FAIL rand_ready[%0d] got=%0h exp=%0h", c, bus.req_ready, exp_rdy); end
            tick();
            m_edge(v, ordy);
            checks++; if (bus.out_valid !== m_valid) begin failures++; $display("FAIL rand_valid[%0d] got=%0h exp=%0h", c, bus.out_valid, m_valid); end
            if (m_valid) begin
                checks++; if (bus.out_data !== m_data || bus.out_idx !== 2'(m_idx)) begin
                    failures++; $display("FAIL rand_word[%0d] got=%0h/%0h exp=%0h/%0h", c, bus.out_data, bus.out_idx, m_data, m_idx);
                end
            end
            v = v & ~exp_rdy;
        end
        bus.req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_skip_wrap();
        test_back_pressure();
        test_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
